alu_operand_loader: RTL and testbench
=====================================

// Module: alu_operand_loader
// PURPOSE
//  Upstream front-end of the lab ALU. Captures operand A, operand B and the opcode from
//  board switches over three confirmed button presses, through a debounce/sync path.
//  Holds them in registers that drive the ALU inputs directly.
//  Validates the opcode before release and pulses go when a full operand set is presented.
// PARAMETERS
//  N               4  operand width; must be >= 4 (opcode comes from sw[3:0])
//  DEBOUNCE_CYCLES 4  consecutive stable synced samples needed to change a debounced level
// PORTS
//  clk           in   1  single clock, all logic rising-edge
//  rst           in   1  synchronous, active-high reset
//  sw            in   N  raw switch value, treated as static when sampled
//  btn_next      in   1  raw confirm button, asynchronous, bouncy
//  btn_back      in   1  raw back button, asynchronous, bouncy
//  a, b          out  N  registered operands to ALU
//  data_shifts   out  N  shift data to ALU; always equals a
//  shift_number  out  N  shift amount to ALU; always equals b
//  operation     out  4  registered opcode to ALU: 0 AND, 1 OR, 2 XOR, 3 SHL, 4 SHR, 5 MOD
//  go            out  1  one-cycle pulse on the clock edge entering SHOW
//  op_error      out  1  one-cycle pulse on a rejected opcode
//  state_o       out  2  current state, 0 LOAD_A, 1 LOAD_B, 2 LOAD_OP, 3 SHOW
// BEHAVIOUR
//  Reset (rst=1 at edge): a=b=0, operation=0, go=0, op_error=0, state LOAD_A.
//   Sync flops, debounce counters and debounced levels = 0; both buttons disarmed.
//  Button path (per button): 2-flop synchronizer -> counter -> debounced level -> rise detect.
//   - Counter increments while synced value != debounced level.
//   - Counter clears whenever they are equal.
//   - Level toggles when the count reaches DEBOUNCE_CYCLES.
//   - press = 1-cycle pulse on a debounced 0->1 change, only if armed.
//   - Armed is set once the debounced level has been 0 after reset.
//     A button held through reset therefore gives no press until released and pressed again.
//  Latency: a clean raw rise sampled at edge k gives press at edge k+DEBOUNCE_CYCLES+2.
//   The state/register update happens on the following edge.
//  FSM, next=press_next, back=press_back:
//   - next & back in the same cycle: both ignored, no state change.
//   - LOAD_A  next: a<=sw -> LOAD_B.  back: ignored.
//   - LOAD_B  next: b<=sw -> LOAD_OP. back: -> LOAD_A; a and b keep their values.
//   - LOAD_OP next:
//       if sw[3:0]>5, or (sw[3:0]==5 and b==0): op_error pulse, stay, operation unchanged;
//       else operation<=sw[3:0] -> SHOW, go=1 for that one cycle.
//   - LOAD_OP back: -> LOAD_B.
//   - SHOW    next: -> LOAD_A, registers unchanged until overwritten. back: -> LOAD_OP.
//  Outputs change only on captures; ALU inputs are stable between captures.
//  Reset mid-sequence aborts immediately: all values above, in-flight press discarded.
//  Widths: sw[N-1:0] captured whole into a/b; only sw[3:0] used for opcode, upper bits ignored.
// TESTING (N=4, DEBOUNCE_CYCLES=4)
//  1 sw=1010,next; sw=1100,next; sw=0000,next -> a=1010 b=1100 operation=0000.
//    go high exactly 1 cycle, state_o=3.
//  2 next bounces 1,0,1,0 (1-cycle each) then held high 12 cycles -> exactly one advance.
//    That advance comes DEBOUNCE_CYCLES+3 edges after the stable rise.
//  3 At LOAD_OP: sw=0111,next -> op_error 1 cycle, state_o=2.
//    b=0000, sw=0101 -> op_error again. Reload b=0110, sw=0101 -> accepted, go pulse.
//  4 At LOAD_OP: back -> state_o=1, a unchanged.
//    next+back together in LOAD_B -> no change. SHOW+back -> state_o=2.
//  5 rst during LOAD_OP with btn_next held -> outputs 0, state_o=0.
//    No advance until btn_next released and re-pressed.
//  6 a=1110, b=0010, op=0011 -> data_shifts=1110, shift_number=0010, operation=0011.

Source files
------------

// File: rtl/alu_operand_loader_if.sv
// Bundle between the switch/button front panel and the operand loader's ALU-facing outputs.
interface alu_operand_loader_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0] sw;
  logic         btn_next;
  logic         btn_back;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] data_shifts;
  logic [N-1:0] shift_number;
  logic [3:0]   operation;
  logic         go;
  logic         op_error;
  logic [1:0]   state_o;

  modport master (
    output sw, btn_next, btn_back,
    input  a, b, data_shifts, shift_number, operation, go, op_error, state_o
  );

  modport slave (
    input  sw, btn_next, btn_back,
    output a, b, data_shifts, shift_number, operation, go, op_error, state_o
  );
endinterface

// File: rtl/alu_operand_loader.sv
// Lab ALU front-end: debounced next/back buttons step through loading A, B and the opcode
// from the switches, holding them in registers that feed the ALU directly.
module alu_operand_loader #(
  parameter int unsigned N               = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  alu_operand_loader_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned NBTN  = 2;
  localparam int unsigned OP_W  = 4;
  localparam logic [OP_W-1:0]  OP_MOD   = OP_W'(5);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    SHOW    = 2'd3
  } state_e;

  // Bit 0 is the next button, bit 1 the back button.
  logic [NBTN-1:0]  sync1_q, sync1_d;
  logic [NBTN-1:0]  sync2_q, sync2_d;
  logic [NBTN-1:0]  level_q, level_d;
  logic [NBTN-1:0]  level_dly_q, level_dly_d;
  logic [NBTN-1:0]  armed_q, armed_d;
  logic [NBTN-1:0]  press_q, press_d;
  logic [CNT_W-1:0] cnt_q [NBTN];
  logic [CNT_W-1:0] cnt_d [NBTN];
  logic [1:0]       fill_q, fill_d;

  state_e          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            go_q, go_d;
  logic            op_error_q, op_error_d;

  logic            next_c;
  logic            back_c;
  logic [OP_W-1:0] op_sw_c;

  assign next_c  = press_q[0] & ~press_q[1];
  assign back_c  = press_q[1] & ~press_q[0];
  assign op_sw_c = bus.sw[OP_W-1:0];

  // Synchronize, debounce and edge-detect both buttons.
  // fill_q marks when the sync chain holds real post-reset samples, so a button held
  // through reset cannot arm itself from the cleared sync flops.
  always_comb begin
    sync1_d     = {bus.btn_back, bus.btn_next};
    sync2_d     = sync1_q;
    fill_d      = {fill_q[0], 1'b1};
    level_d     = level_q;
    level_dly_d = level_q;
    armed_d     = armed_q;
    press_d     = level_q & ~level_dly_q & armed_q;
    for (int i = 0; i < int'(NBTN); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = ~level_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
      if (fill_q[1] && !sync2_q[i] && !level_q[i]) begin
        armed_d[i] = 1'b1;
      end
    end
  end

  // Load sequencer; next and back together cancel each other.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    go_d       = 1'b0;
    op_error_d = 1'b0;
    case (state_q)
      LOAD_A: begin
        if (next_c) begin
          a_d     = bus.sw;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (next_c) begin
          b_d     = bus.sw;
          state_d = LOAD_OP;
        end else if (back_c) begin
          state_d = LOAD_A;
        end
      end
      LOAD_OP: begin
        if (next_c) begin
          // Reject undefined opcodes and a remainder operation with a zero divisor.
          if ((op_sw_c > OP_MOD) || ((op_sw_c == OP_MOD) && (b_q == '0))) begin
            op_error_d = 1'b1;
          end else begin
            op_d    = op_sw_c;
            go_d    = 1'b1;
            state_d = SHOW;
          end
        end else if (back_c) begin
          state_d = LOAD_B;
        end
      end
      SHOW: begin
        if (next_c) begin
          state_d = LOAD_A;
        end else if (back_c) begin
          state_d = LOAD_OP;
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      armed_q     <= '0;
      press_q     <= '0;
      fill_q      <= '0;
      for (int i = 0; i < int'(NBTN); i++) begin
        cnt_q[i] <= '0;
      end
      state_q    <= LOAD_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      go_q       <= 1'b0;
      op_error_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      armed_q     <= armed_d;
      press_q     <= press_d;
      fill_q      <= fill_d;
      for (int i = 0; i < int'(NBTN); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      go_q       <= go_d;
      op_error_q <= op_error_d;
    end
  end

  assign bus.a            = a_q;
  assign bus.b            = b_q;
  assign bus.data_shifts  = a_q;
  assign bus.shift_number = b_q;
  assign bus.operation    = op_q;
  assign bus.go           = go_q;
  assign bus.op_error     = op_error_q;
  assign bus.state_o      = state_q;
endmodule

// File: tb/tb_alu_operand_loader.sv
// Scoreboard bench for alu_operand_loader: button presses feed a step-level model whose
// expected events are queued and checked by an independent output monitor.
module tb_alu_operand_loader;
  localparam int unsigned N  = 4;
  localparam int unsigned DC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_operand_loader_if #(.N(N)) bus ();

  alu_operand_loader #(.N(N), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   st;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   op;
    logic         go;
    logic         err;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;

  // Reference model: position in the load sequence plus captured values.
  int           m_state;
  logic [N-1:0] m_a, m_b;
  logic [3:0]   m_op;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Monitor: any state change, go or op_error is an event that must match the queue head.
  initial begin : monitor
    logic [1:0] prev_st;
    exp_t       e;
    prev_st = 2'd0;
    forever begin
      @(negedge clk);
      if (mon_en && (bus.state_o != prev_st || bus.go || bus.op_error)) begin
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event state=%0d go=%0b op_error=%0b a=%h b=%h",
                   bus.state_o, bus.go, bus.op_error, bus.a, bus.b);
        end else begin
          e = sb_q.pop_front();
          if (bus.state_o !== e.st || bus.a !== e.a || bus.b !== e.b ||
              bus.operation !== e.op || bus.go !== e.go || bus.op_error !== e.err ||
              bus.data_shifts !== e.a || bus.shift_number !== e.b) begin
            fails++;
            $display("FAIL event got st=%0d a=%h b=%h op=%h go=%b err=%b ds=%h sn=%h, expected st=%0d a=%h b=%h op=%h go=%b err=%b",
                     bus.state_o, bus.a, bus.b, bus.operation, bus.go, bus.op_error,
                     bus.data_shifts, bus.shift_number, e.st, e.a, e.b, e.op, e.go, e.err);
          end
        end
      end
      prev_st = bus.state_o;
    end
  end

  task automatic model_reset();
    m_state = 0;
    m_a     = '0;
    m_b     = '0;
    m_op    = '0;
  endtask

  // One button action: update the model, queue its event, then drive the raw button.
  task automatic do_press(input bit nx, input bit bk, input logic [N-1:0] swv, input bit bounce);
    exp_t       e;
    bit         ev;
    bit         seen;
    int         lat;
    logic [1:0] st0;
    logic [3:0] opc;
    ev    = 1'b0;
    e.go  = 1'b0;
    e.err = 1'b0;
    opc   = swv[3:0];
    if (nx && !bk) begin
      ev = 1'b1;
      case (m_state)
        0: begin m_a = swv; m_state = 1; end
        1: begin m_b = swv; m_state = 2; end
        2: begin
          if (opc > 4'd5 || (opc == 4'd5 && m_b == '0)) e.err = 1'b1;
          else begin m_op = opc; m_state = 3; e.go = 1'b1; end
        end
        default: m_state = 0;
      endcase
    end else if (bk && !nx && m_state != 0) begin
      ev      = 1'b1;
      m_state = m_state - 1;
    end
    e.st = 2'(m_state);
    e.a  = m_a;
    e.b  = m_b;
    e.op = m_op;
    if (ev) sb_q.push_back(e);

    @(negedge clk);
    bus.sw = swv;
    if (bounce) begin
      repeat (2) begin
        bus.btn_next = nx; bus.btn_back = bk;
        @(negedge clk);
        bus.btn_next = 1'b0; bus.btn_back = 1'b0;
        @(negedge clk);
      end
    end
    bus.btn_next = nx;
    bus.btn_back = bk;
    st0  = bus.state_o;
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (!seen && (bus.state_o != st0 || bus.go || bus.op_error)) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    if (ev) check("press_latency", lat, int'(DC) + 4);
    @(negedge clk);
    bus.btn_next = 1'b0;
    bus.btn_back = 1'b0;
    repeat (10) @(negedge clk);
    check("queue_drained", sb_q.size(), 0);
  endtask

  initial begin : timeout
    #1000000;
    $display("FAIL global_timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.sw       = '0;
    bus.btn_next = 1'b0;
    bus.btn_back = 1'b0;
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_a", bus.a, 0);
    check("reset_b", bus.b, 0);
    check("reset_op", bus.operation, 0);
    check("reset_go", bus.go, 0);
    check("reset_state", bus.state_o, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    mon_en = 1'b1;

    // Basic load to SHOW with AND.
    do_press(1, 0, 4'b1010, 0);
    do_press(1, 0, 4'b1100, 0);
    do_press(1, 0, 4'b0000, 0);
    check("show_state", bus.state_o, 3);
    // Shift-operand mirror.
    do_press(1, 0, 4'b0000, 0);
    do_press(1, 0, 4'b1110, 0);
    do_press(1, 0, 4'b0010, 0);
    do_press(1, 0, 4'b0011, 0);
    check("data_shifts", bus.data_shifts, 4'b1110);
    check("shift_number", bus.shift_number, 4'b0010);
    // Bouncy press from SHOW.
    do_press(1, 0, 4'b0000, 1);
    // Opcode validation.
    do_press(1, 0, 4'b0011, 0);
    do_press(1, 0, 4'b0000, 0);
    do_press(1, 0, 4'b0111, 0);
    do_press(1, 0, 4'b0101, 0);
    do_press(0, 1, 4'b0000, 0);
    do_press(1, 0, 4'b0110, 0);
    do_press(1, 0, 4'b0101, 0);
    // Back navigation and simultaneous presses.
    do_press(0, 1, 4'b0000, 0);
    do_press(0, 1, 4'b0000, 0);
    do_press(1, 1, 4'b1111, 0);
    do_press(1, 0, 4'b1001, 0);
    do_press(1, 0, 4'b0001, 0);
    do_press(0, 1, 4'b0000, 0);
    check("back_from_show", bus.state_o, 2);

    // Reset in LOAD_OP while next is held; no press until released and re-pressed.
    mon_en = 1'b0;
    @(negedge clk);
    bus.btn_next = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_mid_a", bus.a, 0);
    check("rst_mid_b", bus.b, 0);
    check("rst_mid_op", bus.operation, 0);
    check("rst_mid_state", bus.state_o, 0);
    model_reset();
    @(negedge clk);
    mon_en = 1'b1;
    repeat (14) @(negedge clk);
    bus.btn_next = 1'b0;
    repeat (12) @(negedge clk);
    check("held_no_advance", bus.state_o, 0);
    do_press(1, 0, 4'b0101, 0);

    // Randomized sequences.
    repeat (40) begin
      int   r;
      bit   nx, bk;
      logic [N-1:0] swv;
      r   = int'($urandom_range(0, 99));
      nx  = (r < 60) || (r >= 85);
      bk  = (r >= 60);
      swv = N'($urandom);
      do_press(nx, bk, swv, 1'($urandom_range(0, 1)));
    end
    check("final_state", bus.state_o, m_state);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
